// File: rtl/spdif_tx_scheduler.sv
// rtl/spdif_tx_scheduler.sv - S/PDIF transmit sequencer: FIFO pair fetch, L/R subframe presentation, block position, underrun handling
module spdif_tx_scheduler #(
  parameter int DATA_W       = 20,
  parameter int BLOCK_FRAMES = 192,
  parameter int MUTE_LIMIT   = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic                fifo_empty,
  input  logic [2*DATA_W-1:0] fifo_dout,
  output logic                fifo_rd_en,
  input  logic                frame_ready,
  output logic                fifo_ready,
  output logic [DATA_W-1:0]   tx_din,
  output logic                tx_channel,
  output logic                tx_invalid,
  output logic                tx_block_start,
  output logic [7:0]          frame_index,
  output logic [15:0]         underrun_count,
  output logic                muted
);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_FETCH     = 3'd1;
  localparam logic [2:0] S_WAIT_DATA = 3'd2;
  localparam logic [2:0] S_PRESENT_L = 3'd3;
  localparam logic [2:0] S_PRESENT_R = 3'd4;

  localparam int CW = $clog2(MUTE_LIMIT + 1);
  localparam logic [CW-1:0] CONSEC_MAX  = CW'(MUTE_LIMIT);
  localparam logic [CW-1:0] CONSEC_LAST = CW'(MUTE_LIMIT - 1);
  localparam logic [7:0]    LAST_FRAME  = 8'(BLOCK_FRAMES - 1);

  logic [2:0]        state;
  logic              avail_q;
  logic [DATA_W-1:0] right_q;
  logic [CW-1:0]     consec;

  // FIFO occupancy is registered on the edge that enters FETCH; only we pop, so a
  // non-empty FIFO seen then stays non-empty, and the pop strobe stays a pure state decode.
  assign fifo_rd_en = (state == S_FETCH) && avail_q;
  assign fifo_ready = (state == S_PRESENT_L) || (state == S_PRESENT_R);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= S_IDLE;
      avail_q        <= 1'b0;
      right_q        <= '0;
      consec         <= '0;
      tx_din         <= '0;
      tx_channel     <= 1'b0;
      tx_invalid     <= 1'b1;
      tx_block_start <= 1'b0;
      frame_index    <= '0;
      underrun_count <= '0;
      muted          <= 1'b0;
    end else begin
      avail_q <= !fifo_empty;
      case (state)
        S_IDLE: begin
          frame_index <= '0;
          if (enable) state <= S_FETCH;
        end
        S_FETCH: begin
          if (avail_q) begin
            state <= S_WAIT_DATA;
          end else begin
            tx_din         <= '0;
            right_q        <= '0;
            tx_invalid     <= 1'b1;
            tx_channel     <= 1'b0;
            tx_block_start <= (frame_index == 8'd0);
            if (underrun_count != 16'hFFFF) underrun_count <= underrun_count + 16'd1;
            if (consec < CONSEC_MAX) consec <= consec + 1'b1;
            if (consec >= CONSEC_LAST) muted <= 1'b1;
            state <= S_PRESENT_L;
          end
        end
        S_WAIT_DATA: begin
          tx_din         <= fifo_dout[2*DATA_W-1:DATA_W];
          right_q        <= fifo_dout[DATA_W-1:0];
          tx_invalid     <= 1'b0;
          tx_channel     <= 1'b0;
          tx_block_start <= (frame_index == 8'd0);
          consec         <= '0;
          muted          <= 1'b0;
          state          <= S_PRESENT_L;
        end
        S_PRESENT_L: begin
          if (frame_ready) begin
            tx_din         <= right_q;
            tx_channel     <= 1'b1;
            tx_block_start <= 1'b0;
            state          <= S_PRESENT_R;
          end
        end
        S_PRESENT_R: begin
          if (frame_ready) begin
            if (enable) begin
              frame_index <= (frame_index == LAST_FRAME) ? 8'd0 : frame_index + 8'd1;
              state       <= S_FETCH;
            end else begin
              frame_index <= '0;
              state       <= S_IDLE;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spdif_tx_scheduler.sv
// tb/tb_spdif_tx_scheduler.sv - directed self-checking bench for spdif_tx_scheduler
module tb_spdif_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic        fifo_empty;
  logic [39:0] fifo_dout = '0;
  logic        fifo_rd_en;
  logic        frame_ready;
  logic        fifo_ready;
  logic [19:0] tx_din;
  logic        tx_channel;
  logic        tx_invalid;
  logic        tx_block_start;
  logic [7:0]  frame_index;
  logic [15:0] underrun_count;
  logic        muted;

  int total = 0;
  int bad = 0;
  int rd_count = 0;
  int pop_empty = 0;
  logic [39:0] fq[$];

  spdif_tx_scheduler dut (
    .clk(clk), .rst_n(rst_n), .enable(enable), .fifo_empty(fifo_empty),
    .fifo_dout(fifo_dout), .fifo_rd_en(fifo_rd_en), .frame_ready(frame_ready),
    .fifo_ready(fifo_ready), .tx_din(tx_din), .tx_channel(tx_channel),
    .tx_invalid(tx_invalid), .tx_block_start(tx_block_start),
    .frame_index(frame_index), .underrun_count(underrun_count), .muted(muted)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (fq.size() == 0);

  // FIFO model: data appears on fifo_dout the cycle after the pop strobe
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      rd_count++;
      if (fq.size() == 0) pop_empty++;
      else fifo_dout <= fq.pop_front();
    end
  end

  task automatic wait_present();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (fifo_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL wait_present: fifo_ready=%b required 1 within 100 cycles", fifo_ready);
    end
  endtask

  task automatic pulse_ready();
    frame_ready = 1'b1;
    @(negedge clk);
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    total++; if (fifo_ready !== 1'b0) begin bad++; $display("FAIL rst_fifo_ready got=%b exp=0", fifo_ready); end
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rst_rd_en got=%b exp=0", fifo_rd_en); end
    total++; if (tx_din !== 20'h0) begin bad++; $display("FAIL rst_din got=%h exp=0", tx_din); end
    total++; if (tx_channel !== 1'b0) begin bad++; $display("FAIL rst_channel got=%b exp=0", tx_channel); end
    total++; if (tx_invalid !== 1'b1) begin bad++; $display("FAIL rst_invalid got=%b exp=1", tx_invalid); end
    total++; if (tx_block_start !== 1'b0) begin bad++; $display("FAIL rst_block_start got=%b exp=0", tx_block_start); end
    total++; if (frame_index !== 8'd0) begin bad++; $display("FAIL rst_index got=%0d exp=0", frame_index); end
    total++; if (underrun_count !== 16'd0) begin bad++; $display("FAIL rst_underrun got=%0d exp=0", underrun_count); end
    total++; if (muted !== 1'b0) begin bad++; $display("FAIL rst_muted got=%b exp=0", muted); end
  endtask

  task automatic test_steady();
    logic [19:0] exp_din [6];
    int rd0;
    exp_din = '{20'h12345, 20'hABCDE, 20'h11111, 20'h22222, 20'h33333, 20'h44444};
    fq.push_back({20'h12345, 20'hABCDE});
    fq.push_back({20'h11111, 20'h22222});
    fq.push_back({20'h33333, 20'h44444});
    rd0 = rd_count;
    enable = 1'b1;
    for (int s = 0; s < 6; s++) begin
      wait_present();
      total++; if (tx_din !== exp_din[s]) begin bad++; $display("FAIL steady_din[%0d] got=%h exp=%h", s, tx_din, exp_din[s]); end
      total++; if (tx_channel !== 1'(s % 2)) begin bad++; $display("FAIL steady_channel[%0d] got=%b exp=%0d", s, tx_channel, s % 2); end
      total++; if (tx_invalid !== 1'b0) begin bad++; $display("FAIL steady_invalid[%0d] got=%b exp=0", s, tx_invalid); end
      total++; if (tx_block_start !== (s == 0)) begin bad++; $display("FAIL steady_block_start[%0d] got=%b exp=%0d", s, tx_block_start, s == 0); end
      if (s == 5) enable = 1'b0;
      pulse_ready();
    end
    repeat (4) @(negedge clk);
    total++; if (rd_count - rd0 !== 3) begin bad++; $display("FAIL steady_pops got=%0d exp=3", rd_count - rd0); end
    total++; if (fifo_ready !== 1'b0) begin bad++; $display("FAIL steady_idle_ready got=%b exp=0", fifo_ready); end
  endtask

  task automatic test_spurious();
    fq.push_back({20'hCAFE1, 20'hBEEF2});
    enable = 1'b1;
    @(negedge clk);
    total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL spur_rd_en got=%b exp=1", fifo_rd_en); end
    frame_ready = 1'b1;
    @(negedge clk);
    total++; if (fifo_ready !== 1'b0) begin bad++; $display("FAIL spur_wait_ready got=%b exp=0", fifo_ready); end
    @(negedge clk);
    frame_ready = 1'b0;
    total++; if (fifo_ready !== 1'b1) begin bad++; $display("FAIL spur_present got=%b exp=1", fifo_ready); end
    total++; if (tx_channel !== 1'b0) begin bad++; $display("FAIL spur_channel got=%b exp=0", tx_channel); end
    total++; if (tx_din !== 20'hCAFE1) begin bad++; $display("FAIL spur_left got=%h exp=cafe1", tx_din); end
    enable = 1'b0;
    pulse_ready();
    wait_present();
    total++; if (tx_din !== 20'hBEEF2) begin bad++; $display("FAIL spur_right got=%h exp=beef2", tx_din); end
    pulse_ready();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_enable_drop();
    int rd0;
    fq.push_back({20'h00001, 20'h00002});
    fq.push_back({20'h00003, 20'h00004});
    fq.push_back({20'h00005, 20'h00006});
    rd0 = rd_count;
    enable = 1'b1;
    wait_present(); pulse_ready();
    wait_present(); pulse_ready();
    wait_present();
    total++; if (frame_index !== 8'd1) begin bad++; $display("FAIL drop_index1 got=%0d exp=1", frame_index); end
    total++; if (tx_din !== 20'h00003) begin bad++; $display("FAIL drop_left got=%h exp=00003", tx_din); end
    enable = 1'b0;
    pulse_ready();
    wait_present();
    total++; if (tx_channel !== 1'b1) begin bad++; $display("FAIL drop_right_channel got=%b exp=1", tx_channel); end
    total++; if (tx_din !== 20'h00004) begin bad++; $display("FAIL drop_right got=%h exp=00004", tx_din); end
    pulse_ready();
    repeat (3) @(negedge clk);
    total++; if (fifo_ready !== 1'b0) begin bad++; $display("FAIL drop_idle_ready got=%b exp=0", fifo_ready); end
    total++; if (frame_index !== 8'd0) begin bad++; $display("FAIL drop_idle_index got=%0d exp=0", frame_index); end
    total++; if (rd_count - rd0 !== 2) begin bad++; $display("FAIL drop_pops got=%0d exp=2", rd_count - rd0); end
    enable = 1'b1;
    wait_present();
    total++; if (tx_block_start !== 1'b1) begin bad++; $display("FAIL drop_reenable_bs got=%b exp=1", tx_block_start); end
    total++; if (tx_din !== 20'h00005) begin bad++; $display("FAIL drop_reenable_din got=%h exp=00005", tx_din); end
    enable = 1'b0;
    pulse_ready(); wait_present(); pulse_ready();
    repeat (3) @(negedge clk);
  endtask

  task automatic test_block_wrap();
    for (int f = 0; f < 200; f++) fq.push_back({20'(f), 20'(f) + 20'h80000});
    enable = 1'b1;
    for (int f = 0; f < 200; f++) begin
      wait_present();
      total++; if (frame_index !== 8'(f % 192)) begin bad++; $display("FAIL wrap_index[%0d] got=%0d exp=%0d", f, frame_index, f % 192); end
      total++; if (tx_block_start !== (f % 192 == 0)) begin bad++; $display("FAIL wrap_bs_left[%0d] got=%b exp=%0d", f, tx_block_start, f % 192 == 0); end
      total++; if (tx_din !== 20'(f)) begin bad++; $display("FAIL wrap_left[%0d] got=%h exp=%h", f, tx_din, 20'(f)); end
      if (f == 199) enable = 1'b0;
      pulse_ready();
      wait_present();
      total++; if (tx_block_start !== 1'b0) begin bad++; $display("FAIL wrap_bs_right[%0d] got=%b exp=0", f, tx_block_start); end
      total++; if (tx_din !== 20'(f) + 20'h80000) begin bad++; $display("FAIL wrap_right[%0d] got=%h exp=%h", f, tx_din, 20'(f) + 20'h80000); end
      pulse_ready();
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_underrun();
    int rd0;
    rd0 = rd_count;
    enable = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      wait_present();
      total++; if (tx_din !== 20'h0) begin bad++; $display("FAIL ur_left_din[%0d] got=%h exp=0", k, tx_din); end
      total++; if (tx_invalid !== 1'b1) begin bad++; $display("FAIL ur_left_inv[%0d] got=%b exp=1", k, tx_invalid); end
      total++; if (underrun_count !== 16'(k)) begin bad++; $display("FAIL ur_count[%0d] got=%0d exp=%0d", k, underrun_count, k); end
      total++; if (muted !== (k >= 4)) begin bad++; $display("FAIL ur_muted[%0d] got=%b exp=%0d", k, muted, k >= 4); end
      pulse_ready();
      wait_present();
      total++; if (tx_din !== 20'h0) begin bad++; $display("FAIL ur_right_din[%0d] got=%h exp=0", k, tx_din); end
      total++; if (tx_invalid !== 1'b1) begin bad++; $display("FAIL ur_right_inv[%0d] got=%b exp=1", k, tx_invalid); end
      if (k == 5) fq.push_back({20'h5A5A5, 20'h0F0F0});
      pulse_ready();
    end
    total++; if (rd_count - rd0 !== 0) begin bad++; $display("FAIL ur_no_pop got=%0d exp=0", rd_count - rd0); end
    wait_present();
    total++; if (tx_din !== 20'h5A5A5) begin bad++; $display("FAIL ur_recover_din got=%h exp=5a5a5", tx_din); end
    total++; if (tx_invalid !== 1'b0) begin bad++; $display("FAIL ur_recover_inv got=%b exp=0", tx_invalid); end
    total++; if (muted !== 1'b0) begin bad++; $display("FAIL ur_recover_muted got=%b exp=0", muted); end
    total++; if (underrun_count !== 16'd5) begin bad++; $display("FAIL ur_final_count got=%0d exp=5", underrun_count); end
    enable = 1'b0;
    pulse_ready();
    wait_present();
    total++; if (tx_din !== 20'h0F0F0) begin bad++; $display("FAIL ur_recover_right got=%h exp=0f0f0", tx_din); end
    pulse_ready();
    repeat (3) @(negedge clk);
    total++; if (pop_empty !== 0) begin bad++; $display("FAIL ur_pop_on_empty got=%0d exp=0", pop_empty); end
  endtask

  task automatic test_reset_mid();
    int rd0;
    fq.push_back({20'h77777, 20'h88888});
    fq.push_back({20'h99999, 20'hAAAAA});
    rd0 = rd_count;
    enable = 1'b1;
    wait_present();
    pulse_ready();
    total++; if (tx_channel !== 1'b1) begin bad++; $display("FAIL rmid_in_right got=%b exp=1", tx_channel); end
    rst_n = 1'b0;
    #1;
    total++; if (fifo_ready !== 1'b0) begin bad++; $display("FAIL rmid_ready got=%b exp=0", fifo_ready); end
    total++; if (tx_din !== 20'h0) begin bad++; $display("FAIL rmid_din got=%h exp=0", tx_din); end
    total++; if (tx_channel !== 1'b0) begin bad++; $display("FAIL rmid_channel got=%b exp=0", tx_channel); end
    total++; if (tx_invalid !== 1'b1) begin bad++; $display("FAIL rmid_invalid got=%b exp=1", tx_invalid); end
    total++; if (underrun_count !== 16'd0) begin bad++; $display("FAIL rmid_underrun got=%0d exp=0", underrun_count); end
    repeat (2) @(negedge clk);
    total++; if (fq.size() !== 1) begin bad++; $display("FAIL rmid_no_pop got=%0d exp=1", fq.size()); end
    rst_n = 1'b1;
    #1;
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rmid_idle_rd got=%b exp=0", fifo_rd_en); end
    @(negedge clk);
    total++; if (fifo_rd_en !== 1'b1) begin bad++; $display("FAIL rmid_fetch_rd got=%b exp=1", fifo_rd_en); end
    @(negedge clk);
    total++; if (fifo_rd_en !== 1'b0) begin bad++; $display("FAIL rmid_wait_rd got=%b exp=0", fifo_rd_en); end
    wait_present();
    total++; if (tx_din !== 20'h99999) begin bad++; $display("FAIL rmid_left got=%h exp=99999", tx_din); end
    total++; if (tx_block_start !== 1'b1) begin bad++; $display("FAIL rmid_bs got=%b exp=1", tx_block_start); end
    enable = 1'b0;
    pulse_ready(); wait_present(); pulse_ready();
    repeat (3) @(negedge clk);
    total++; if (rd_count - rd0 !== 2) begin bad++; $display("FAIL rmid_pops got=%0d exp=2", rd_count - rd0); end
  endtask

  initial begin
    rst_n = 1'b0;
    enable = 1'b0;
    frame_ready = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_steady();
    test_spurious();
    test_enable_drop();
    test_block_wrap();
    test_underrun();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
